apb_controller: RTL and testbench

Master-side APB sequencer of the AHB-to-APB bridge. It accepts one qualified AHB transfer at a time from the AHB slave interface and drives the APB setup and access phases into the APB interface/peripheral stage (`Pwrite`, `Penable`, `Pselx`, `Paddr`, `Pwdata`). It returns `Prdata` to the AHB side as registered `Hrdata`, and throttles the AHB master with `Hreadyout`. The APB side has no `PREADY`, so every APB transfer takes exactly one setup cycle and one access cycle.

---
 rtl/ahb2apb_pkg.sv | 37 +++
 rtl/apb_controller.sv | 110 +++++++++++
 tb/tb_apb_controller.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/ahb2apb_pkg.sv
// Shared definitions for the AHB-to-APB bridge: controller state encoding,
// default bus widths and AHB transfer-type codes used by the upstream decode.
package ahb2apb_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam int SEL_W_DEF  = 3;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_READ_SETUP   = 3'd1,
    ST_READ_ACCESS  = 3'd2,
    ST_WWAIT        = 3'd3,
    ST_WRITE_SETUP  = 3'd4,
    ST_WRITE_ACCESS = 3'd5
  } apb_state_e;

  // True for NONSEQ/SEQ; IDLE and BUSY never start a transfer.
  function automatic logic htrans_is_active(input logic [1:0] htrans);
    return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
  endfunction

  function automatic logic is_apb_phase(input apb_state_e s);
    return (s == ST_READ_SETUP) || (s == ST_READ_ACCESS) ||
           (s == ST_WRITE_SETUP) || (s == ST_WRITE_ACCESS);
  endfunction

  function automatic logic is_access(input apb_state_e s);
    return (s == ST_READ_ACCESS) || (s == ST_WRITE_ACCESS);
  endfunction

endpackage

// File: rtl/apb_controller.sv
// Master-side APB sequencer: one AHB transfer at a time is turned into an APB
// setup + access pair; every output is a flop so nothing leaks from inputs.
module apb_controller
  import ahb2apb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int SEL_W  = SEL_W_DEF
) (
  input  logic              Hclk,
  input  logic              Hreset,
  input  logic              valid,
  input  logic [ADDR_W-1:0] Haddr,
  input  logic              Hwrite,
  input  logic [DATA_W-1:0] Hwdata,
  input  logic [SEL_W-1:0]  temp_selx,
  input  logic [DATA_W-1:0] Prdata,
  output logic              Pwrite,
  output logic              Penable,
  output logic [SEL_W-1:0]  Pselx,
  output logic [ADDR_W-1:0] Paddr,
  output logic [DATA_W-1:0] Pwdata,
  output logic              Hreadyout,
  output logic [DATA_W-1:0] Hrdata
);

  // Handshake: Hreadyout high means the IDLE state is sampling valid this
  // cycle; while it is low upstream holds its request and valid is ignored.

  apb_state_e        state_q, state_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic              pwrite_q, pwrite_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [SEL_W-1:0]  pselx_q, pselx_d;
  logic              penable_q, penable_d;
  logic              hreadyout_q, hreadyout_d;
  logic [DATA_W-1:0] hrdata_q, hrdata_d;

  always_comb begin
    state_d  = state_q;
    paddr_d  = paddr_q;
    pwrite_d = pwrite_q;
    pwdata_d = pwdata_q;
    sel_d    = sel_q;
    hrdata_d = hrdata_q;

    case (state_q)
      ST_IDLE: begin
        // A request with no peripheral selected completes zero-wait here.
        if (valid && (temp_selx != '0)) begin
          paddr_d  = Haddr;
          sel_d    = temp_selx;
          pwrite_d = Hwrite;
          state_d  = Hwrite ? ST_WWAIT : ST_READ_SETUP;
        end
      end
      ST_WWAIT: begin
        pwdata_d = Hwdata;
        state_d  = ST_WRITE_SETUP;
      end
      ST_READ_SETUP:   state_d = ST_READ_ACCESS;
      ST_READ_ACCESS: begin
        hrdata_d = Prdata;
        state_d  = ST_IDLE;
      end
      ST_WRITE_SETUP:  state_d = ST_WRITE_ACCESS;
      ST_WRITE_ACCESS: state_d = ST_IDLE;
      default:         state_d = ST_IDLE;
    endcase

    // Strobes are decoded from the next state so they land in flops.
    pselx_d     = is_apb_phase(state_d) ? sel_d : '0;
    penable_d   = is_access(state_d);
    hreadyout_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset) begin
      state_q     <= ST_IDLE;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      sel_q       <= '0;
      pselx_q     <= '0;
      penable_q   <= 1'b0;
      hreadyout_q <= 1'b1;
      hrdata_q    <= '0;
    end else begin
      state_q     <= state_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      sel_q       <= sel_d;
      pselx_q     <= pselx_d;
      penable_q   <= penable_d;
      hreadyout_q <= hreadyout_d;
      hrdata_q    <= hrdata_d;
    end
  end

  assign Pwrite    = pwrite_q;
  assign Penable   = penable_q;
  assign Pselx     = pselx_q;
  assign Paddr     = paddr_q;
  assign Pwdata    = pwdata_q;
  assign Hreadyout = hreadyout_q;
  assign Hrdata    = hrdata_q;

endmodule

// File: tb/tb_apb_controller.sv
// Self-checking bench for apb_controller: directed cases from the transfer
// timing rules plus randomized transfer streams against a transaction model.
module tb_apb_controller;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int SEL_W  = 3;
  localparam int OBS_W  = SEL_W + 3 + ADDR_W + 2 * DATA_W;

  logic              Hclk = 1'b0;
  logic              Hreset;
  logic              valid;
  logic [ADDR_W-1:0] Haddr;
  logic              Hwrite;
  logic [DATA_W-1:0] Hwdata;
  logic [SEL_W-1:0]  temp_selx;
  logic [DATA_W-1:0] Prdata;
  logic              Pwrite;
  logic              Penable;
  logic [SEL_W-1:0]  Pselx;
  logic [ADDR_W-1:0] Paddr;
  logic [DATA_W-1:0] Pwdata;
  logic              Hreadyout;
  logic [DATA_W-1:0] Hrdata;

  int n_cmp = 0;
  int n_err = 0;

  // Transaction-level model of the architecturally visible registers.
  logic [ADDR_W-1:0] m_paddr;
  logic              m_pwrite;
  logic [DATA_W-1:0] m_pwdata;
  logic [DATA_W-1:0] m_hrdata;

  logic [OBS_W-1:0] got, exp;

  apb_controller #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SEL_W(SEL_W)) dut (
    .Hclk(Hclk), .Hreset(Hreset), .valid(valid), .Haddr(Haddr),
    .Hwrite(Hwrite), .Hwdata(Hwdata), .temp_selx(temp_selx), .Prdata(Prdata),
    .Pwrite(Pwrite), .Penable(Penable), .Pselx(Pselx), .Paddr(Paddr),
    .Pwdata(Pwdata), .Hreadyout(Hreadyout), .Hrdata(Hrdata)
  );

  always #5 Hclk = ~Hclk;

  task automatic step();
    @(posedge Hclk);
    #1;
  endtask

  task automatic observe();
    got = {Pselx, Penable, Hreadyout, Pwrite, Paddr, Pwdata, Hrdata};
  endtask

  task automatic expect_idle(input string name);
    observe();
    exp = {{SEL_W{1'b0}}, 1'b0, 1'b1, m_pwrite, m_paddr, m_pwdata, m_hrdata};
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: sel/en/rdy/wr/addr/wdata/rdata got %h want %h", name, got, exp);
    end
  endtask

  // Issue one transfer from an IDLE cycle; returns in the completing IDLE cycle.
  task automatic do_xfer(input bit wr, input logic [ADDR_W-1:0] addr,
                         input logic [SEL_W-1:0] sel, input logic [DATA_W-1:0] wdata,
                         input logic [DATA_W-1:0] rdata, input string name);
    int nph;
    bit is_setup, is_access;
    valid = 1'b1; Haddr = addr; Hwrite = wr; temp_selx = sel;
    Hwdata = $urandom; Prdata = $urandom;
    observe();
    n_cmp++;
    if (got[OBS_W-SEL_W-2] !== 1'b1) begin
      n_err++;
      $display("FAIL %s accept: Hreadyout got %b want 1", name, got[OBS_W-SEL_W-2]);
    end
    m_paddr = addr; m_pwrite = wr;
    nph = wr ? 3 : 2;
    for (int c = 1; c <= nph; c++) begin
      step();
      // Request lines wander while busy; the controller must ignore them.
      Haddr = $urandom; Hwrite = 1'($urandom_range(0, 1));
      temp_selx = SEL_W'($urandom_range(1, 7));
      Hwdata = (wr && c == 1) ? wdata : $urandom;
      is_access = (c == nph);
      is_setup  = (c == nph - 1);
      Prdata = is_access ? rdata : $urandom;
      if (wr && c == 2) m_pwdata = wdata;
      observe();
      exp = {(is_setup || is_access) ? sel : {SEL_W{1'b0}}, is_access, 1'b0,
             m_pwrite, m_paddr, m_pwdata, m_hrdata};
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL %s cycle %0d: sel/en/rdy/wr/addr/wdata/rdata got %h want %h",
                 name, c, got, exp);
      end
    end
    step();
    valid = 1'b0;
    if (!wr) m_hrdata = rdata;
    expect_idle({name, " done"});
  endtask

  task automatic test_reset();
    Hreset = 1'b1; valid = 1'b0; Haddr = '0; Hwrite = 1'b0;
    Hwdata = '0; temp_selx = '0; Prdata = 32'h1234_5678;
    m_paddr = '0; m_pwrite = 1'b0; m_pwdata = '0; m_hrdata = '0;
    step(); step();
    expect_idle("reset_held");
    Hreset = 1'b0;
    step();
    expect_idle("reset_released");
  endtask

  task automatic test_read();
    do_xfer(1'b0, 32'h8000_0010, 3'b010, 32'h0, 32'h0000_002A, "read_dir");
    n_cmp++;
    if (Hrdata !== 32'h0000_002A) begin
      n_err++;
      $display("FAIL read_hrdata: got %h want 0000002a", Hrdata);
    end
  endtask

  task automatic test_write();
    do_xfer(1'b1, 32'h8400_0004, 3'b100, 32'hDEAD_BEEF, 32'h0, "write_dir");
  endtask

  task automatic test_back_to_back();
    do_xfer(1'b1, 32'h8000_0100, 3'b001, 32'hCAFE_0001, 32'h0, "b2b_write");
    do_xfer(1'b0, 32'h8000_0200, 3'b100, 32'h0, 32'h5A5A_A5A5, "b2b_read");
    do_xfer(1'b0, 32'h8000_0300, 3'b010, 32'h0, 32'h0BAD_F00D, "b2b_read2");
  endtask

  task automatic test_no_select();
    valid = 1'b1; temp_selx = '0; Haddr = 32'hFFFF_0000; Hwrite = 1'b1;
    Hwdata = 32'h1111_2222; Prdata = 32'h7777_7777;
    step();
    expect_idle("nosel_cycle1");
    Hwrite = 1'b0;
    step();
    valid = 1'b0;
    expect_idle("nosel_cycle2");
  endtask

  task automatic test_reset_mid_transfer();
    valid = 1'b1; Haddr = 32'h8000_0040; Hwrite = 1'b1; temp_selx = 3'b001;
    step();
    valid = 1'b0; Hwdata = 32'h0F0F_0F0F;
    step(); step();
    observe();
    n_cmp++;
    if ({Pselx, Penable} !== {3'b001, 1'b1}) begin
      n_err++;
      $display("FAIL mid_reset_in_access: sel/en got %b want 0011", {Pselx, Penable});
    end
    Hreset = 1'b1;
    #1;
    m_paddr = '0; m_pwrite = 1'b0; m_pwdata = '0; m_hrdata = '0;
    expect_idle("mid_reset_immediate");
    step();
    Hreset = 1'b0;
    step();
    expect_idle("mid_reset_after_release");
    step();
    expect_idle("mid_reset_no_reissue");
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        test_no_select();
      end else begin
        do_xfer(1'($urandom_range(0, 1)), $urandom,
                SEL_W'(3'b001 << $urandom_range(0, 2)), $urandom, $urandom, "rand");
      end
      if ($urandom_range(0, 2) == 0) begin
        step();
        expect_idle("rand_gap");
      end
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_back_to_back();
    test_no_select();
    test_reset_mid_transfer();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
